// File: rtl/morse_letter_sequencer.sv
// Morse letter sequencer: ROM lookup of A-H and symbol-at-a-time handshake.
// Define MORSE_LETTER_GAP_EN to add a three-tick inter-letter gap before done.
module morse_letter_sequencer #(
    parameter int TICK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] letter,
    input  logic       elem_ready,
    output logic       tick,
    output logic       sym_valid,
    output logic       sym_dash,
    output logic [2:0] remaining,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(TICK_DIV);

`ifdef MORSE_LETTER_GAP_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_DRAIN = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd4
    } state_t;
`endif

    state_t        state, state_d;
    logic [3:0]    pat, pat_d;
    logic [2:0]    rem, rem_d;
    logic [CW-1:0] cnt;

    // Pattern in [6:3] (MSB first, 1 = dash), symbol count in [2:0]
    function automatic logic [6:0] rom(input logic [2:0] l);
        rom = '0;
        unique case (l)
            3'd0: rom = {4'b0100, 3'd2};
            3'd1: rom = {4'b1000, 3'd4};
            3'd2: rom = {4'b1010, 3'd4};
            3'd3: rom = {4'b1000, 3'd3};
            3'd4: rom = {4'b0000, 3'd1};
            3'd5: rom = {4'b0010, 3'd4};
            3'd6: rom = {4'b1100, 3'd3};
            3'd7: rom = {4'b0000, 3'd4};
        endcase
    endfunction

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

`ifdef MORSE_LETTER_GAP_EN
    logic [1:0] gap, gap_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap <= '0;
        end else begin
            gap <= gap_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pat   <= '0;
            rem   <= '0;
        end else begin
            state <= state_d;
            pat   <= pat_d;
            rem   <= rem_d;
        end
    end

    always_comb begin
        state_d = state;
        pat_d   = pat;
        rem_d   = rem;
`ifdef MORSE_LETTER_GAP_EN
        gap_d   = gap;
`endif
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    {pat_d, rem_d} = rom(letter);
                    state_d        = S_SEND;
                end
            end
            S_SEND: begin
                if (elem_ready) begin
                    pat_d = {pat[2:0], 1'b0};
                    rem_d = rem - 3'd1;
                    if (rem == 3'd1) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (elem_ready) begin
`ifdef MORSE_LETTER_GAP_EN
                    state_d = S_GAP;
                    gap_d   = '0;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MORSE_LETTER_GAP_EN
            S_GAP: begin
                // Third tick seen in GAP ends the inter-letter silence
                if (tick) begin
                    gap_d = gap + 2'd1;
                    if (gap == 2'd2) begin
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign sym_valid = (state == S_SEND);
    assign sym_dash  = pat[3];
    assign remaining = rem;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Randomized self-checking bench for morse_letter_sequencer.
// Expected symbols come from a dot/dash string table of the alphabet.
module tb_morse_letter_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] letter = 3'd0;
    logic       elem_ready = 1'b0;
    logic       tick;
    logic       sym_valid;
    logic       sym_dash;
    logic [2:0] remaining;
    logic       busy;
    logic       done;

    int n_chk = 0;
    int n_fail = 0;

    string pats [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    morse_letter_sequencer #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .letter     (letter),
        .elem_ready (elem_ready),
        .tick       (tick),
        .sym_valid  (sym_valid),
        .sym_dash   (sym_dash),
        .remaining  (remaining),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_letter(input int l, input bit noise, input bit b2b);
        string p;
        int    len;
        int    ticks;
        int    t;
        p   = pats[l];
        len = p.len();
        start  = 1'b1;
        letter = 3'(l);
        step();
        start = 1'b0;
        n_chk++;
        if (sym_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL load L%0d: valid=%b busy=%b done=%b want 1 1 0",
                     l, sym_valid, busy, done);
        end
        for (int i = 0; i < len; i++) begin
            repeat (b2b ? 0 : $urandom_range(0, 2)) begin
                elem_ready = 1'b0;
                if (noise) begin
                    start  = 1'($urandom % 2);
                    letter = 3'($urandom);
                end
                step();
            end
            elem_ready = 1'b1;
            n_chk++;
            if (sym_valid !== 1'b1 || sym_dash !== (p[i] == "-") ||
                remaining !== 3'(len - i)) begin
                n_fail++;
                $display("FAIL sym L%0d[%0d]: valid=%b dash=%b rem=%0d want 1 %b %0d",
                         l, i, sym_valid, sym_dash, remaining,
                         (p[i] == "-"), len - i);
            end
            step();
        end
        elem_ready = 1'b0;
        n_chk++;
        if (sym_valid !== 1'b0 || busy !== 1'b1 || remaining !== 3'd0 ||
            done !== 1'b0) begin
            n_fail++;
            $display("FAIL drain L%0d: valid=%b busy=%b rem=%0d done=%b want 0 1 0 0",
                     l, sym_valid, busy, remaining, done);
        end
        repeat ($urandom_range(0, 2)) begin
            if (noise) begin
                start  = 1'($urandom % 2);
                letter = 3'($urandom);
            end
            step();
            n_chk++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_hold L%0d: busy=%b done=%b want 1 0",
                         l, busy, done);
            end
        end
        elem_ready = 1'b1;
        step();
        elem_ready = 1'b0;
`ifdef MORSE_LETTER_GAP_EN
        ticks = 0;
        t     = 0;
        while (ticks < 3 && t < 40) begin
            n_chk++;
            if (done !== 1'b0 || busy !== 1'b1 || sym_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gap L%0d: done=%b busy=%b valid=%b want 0 1 0",
                         l, done, busy, sym_valid);
            end
            if (tick === 1'b1) ticks++;
            start  = 1'b1;
            letter = 3'($urandom);
            step();
            t++;
        end
        start = 1'b0;
        n_chk++;
        if (ticks < 3) begin
            n_fail++;
            $display("FAIL gap_timeout L%0d: ticks=%0d want 3", l, ticks);
        end
`else
        ticks = 0;
        t     = 0;
`endif
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b1 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done L%0d: done=%b busy=%b valid=%b want 1 1 0",
                     l, done, busy, sym_valid);
        end
        if (noise) begin
            start  = 1'b1;
            letter = 3'($urandom);
        end
        step();
        start = 1'b0;
        n_chk++;
        if (done !== 1'b0 || busy !== 1'b0 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle L%0d: done=%b busy=%b valid=%b want 0 0 0",
                     l, done, busy, sym_valid);
        end
    endtask

    task automatic test_reset();
        #2;
        n_chk++;
        if ({tick, sym_valid, sym_dash, remaining, busy, done} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_hold: outs=%b want 0", {tick, sym_valid,
                     sym_dash, remaining, busy, done});
        end
        #10 reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_chk++;
            if (tick !== ((k % 4) == 3)) begin
                n_fail++;
                $display("FAIL tick_c%0d: tick=%b want %b", k, tick, (k % 4) == 3);
            end
        end
        elem_ready = 1'b1;
        step();
        step();
        elem_ready = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || sym_valid !== 1'b0 || remaining !== 3'd0) begin
            n_fail++;
            $display("FAIL idle_ready: busy=%b valid=%b rem=%0d want 0 0 0",
                     busy, sym_valid, remaining);
        end
    endtask

    task automatic test_reset_mid();
        start  = 1'b1;
        letter = 3'd1;
        step();
        start      = 1'b0;
        elem_ready = 1'b1;
        step();
        elem_ready = 1'b0;
        n_chk++;
        if (remaining !== 3'd3 || sym_dash !== 1'b0 || sym_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b_second: rem=%0d dash=%b valid=%b want 3 0 1",
                     remaining, sym_dash, sym_valid);
        end
        step();
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({tick, sym_valid, sym_dash, remaining, busy, done} !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: outs=%b want 0", {tick, sym_valid,
                     sym_dash, remaining, busy, done});
        end
        #1 reset = 1'b0;
        step();
        n_chk++;
        if (busy !== 1'b0 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: busy=%b valid=%b want 0 0", busy, sym_valid);
        end
        send_letter(6, 1'b0, 1'b0);
    endtask

    task automatic test_letters();
        send_letter(2, 1'b0, 1'b0);
        send_letter(4, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        send_letter(0, 1'b1, 1'b0);
        send_letter(7, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_letter(5, 1'b0, 1'b1);
        send_letter(1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 3)) step();
            send_letter(int'($urandom_range(0, 7)), 1'b1, 1'($urandom % 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_letters();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_letter_sequencer.md
# morse_letter_sequencer

Upstream stage for the Morse element FSM. Accepts a 3-bit letter code (A–H), looks up its dot/dash pattern and length, and presents one symbol at a time on a valid/ready handshake. The element FSM consumes each symbol and reports readiness. The block also generates the half-second `tick` enable pulse that paces the element FSM, and it signals `done` once the whole letter has been emitted.

## Interface
- `TICK_DIV`, default 25000000: clock cycles per `tick` (0.5 s at 50 MHz); must be ≥ 2.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  request to send `letter`; sampled only when idle.
- `letter`  input  3  letter code: 0=A, 1=B, 2=C, 3=D, 4=E, 5=F, 6=G, 7=H.
- `elem_ready`  input  1  element FSM is idle at an enable tick and will take a symbol this cycle.
- `tick`  output  1  one-cycle pulse every `TICK_DIV` cycles; drives element FSM enable.
- `sym_valid`  output  1  a symbol is presented.
- `sym_dash`  output  1  current symbol: 1 = dash, 0 = dot.
- `remaining`  output  3  symbols not yet consumed (0–4).
- `busy`  output  1  high whenever not in IDLE.
- `done`  output  1  one-cycle pulse when the letter is complete.

## Operation
- Pattern ROM (MSB-first, 1 = dash, length in parentheses):
  - A 0100 (2), B 1000 (4), C 1010 (4), D 1000 (3)
  - E 0000 (1), F 0010 (4), G 1100 (3), H 0000 (4)
- Registers: 4-bit shift register `pat`, 3-bit `remaining`, state.
- `sym_dash` = `pat[3]`. `sym_valid` = (state == SEND).
- States:
  - IDLE: when `start`=1, load `pat`/`remaining` from ROM[`letter`] and go to SEND. Otherwise stay.
  - SEND: a symbol is consumed when `sym_valid & elem_ready`. On consume, `pat` shifts left with 0 fill and `remaining` decrements. If `remaining` was 1, go to DRAIN.
  - DRAIN: wait for `elem_ready`=1, which means the element FSM has finished the last symbol. Then go to GAP (macro on) or DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Tick counter: free-running from reset, width ceil(log2(`TICK_DIV`)). `tick`=1 when count == `TICK_DIV`-1; the count then wraps to 0. The counter is independent of the state machine.
- Boundary conditions:
  - `start` while `busy`: ignored; `letter` is not re-sampled.
  - `start` during the DONE cycle: ignored.
  - `elem_ready` in IDLE or DONE: ignored.
  - `letter` changing after load: no effect.
  - `reset` asserted at any time: all state and outputs cleared at once; an in-flight letter is abandoned.
- Arithmetic: `remaining` never underflows, because the decrement happens only in SEND where `remaining` ≥ 1.

## Timing
- Reset values: `tick`=0, `sym_valid`=0, `sym_dash`=0, `remaining`=0, `busy`=0, `done`=0; state IDLE; tick count 0.
- Start latency: `start` sampled high at edge N gives `sym_valid`=1 with the first symbol from edge N onward (registered, visible in cycle N+1).
- Consume: the handshake at edge M presents the next symbol (or DRAIN) from edge M. Back-to-back consumes on consecutive cycles are legal.
- `done` is high for exactly one cycle. `busy` falls in the cycle after `done`.
- All outputs are driven from registers; there is no combinational path from inputs to outputs.
- First `tick` after reset release arrives at cycle `TICK_DIV`-1, then every `TICK_DIV` cycles.

## Configuration
- `MORSE_LETTER_GAP_EN` defined:
  - DRAIN exits to a GAP state that counts 3 `tick` pulses (inter-letter gap) before going to DONE.
  - `busy` stays high through GAP.
- `MORSE_LETTER_GAP_EN` undefined:
  - The GAP state does not exist; DRAIN goes directly to DONE.

## Test plan
- Reset: assert `reset` mid-cycle → all outputs 0 asynchronously. Release with `TICK_DIV`=4 → `tick` pulses at cycles 3, 7, 11.
- Letter C, with `elem_ready` pulsed one cycle after each symbol → `sym_dash` sequence 1,0,1,0; `remaining` 4,3,2,1. After a final `elem_ready` in DRAIN, one `done` pulse; `busy` is 0 the next cycle.
- Letter E → a single dot (`sym_dash`=0, `remaining`=1). After consume, state is DRAIN; `done` follows the next `elem_ready`.
- `start` with letter H while sending A → ignored; sequence is dot, dash, then `done`. A new `start` after `done` sends H as four dots.
- `reset` pulse after the first symbol of B is consumed → `sym_valid`=0, `remaining`=0, `busy`=0. A following `start` with G sends dash, dash, dot.
- With `MORSE_LETTER_GAP_EN`, letter A → `done` fires only after 3 `tick` pulses following the DRAIN exit, and `start` is ignored during the gap.
